// File: rtl/phrase_pkg.sv
// rtl/phrase_pkg.sv - shared types and constants for the phrase store and its entry ALU
// Build option: PHRASE_STORE_CLEAR_EN adds the phrase-clear sweep state.
package phrase_pkg;

  typedef struct packed {
    logic [7:0] note;
    logic [5:0] vol;
    logic [1:0] inst;
  } entry_t;

  localparam logic [15:0] EMPTY_ENTRY = 16'hFFFF;
  localparam logic [7:0]  BASE_NOTE   = 8'd36;
  localparam logic [5:0]  BASE_VOL    = 6'd50;
  localparam logic [1:0]  BASE_INST   = 2'd0;
  localparam logic [5:0]  VOL_MAX     = 6'd63;
  localparam logic [1:0]  INST_MAX    = 2'd3;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_DEL   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    FLD_NOTE = 2'b00,
    FLD_OCT  = 2'b01,
    FLD_VOL  = 2'b10,
    FLD_INST = 2'b11
  } cmd_field_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MODIFY,
    ST_DONE,
    ST_ERR
`ifdef PHRASE_STORE_CLEAR_EN
    , ST_SWEEP
`endif
  } state_e;

endpackage

// File: rtl/phrase_entry_alu.sv
// rtl/phrase_entry_alu.sv - combinational new-value calculation for one tracker entry
module phrase_entry_alu
  import phrase_pkg::*;
#(
  parameter int NOTE_MAX = 107
) (
  input  cmd_op_e    op_i,
  input  cmd_field_e field_i,
  input  entry_t     entry_i,
  output entry_t     entry_o
);

  localparam logic [7:0] NMAX = NOTE_MAX[7:0];

  entry_t seed;

  always_comb begin
    // An empty slot behaves as a fresh default note before the edit is applied
    seed    = (entry_i == EMPTY_ENTRY) ? entry_t'{BASE_NOTE, BASE_VOL, BASE_INST} : entry_i;
    entry_o = seed;
    case (op_i)
      OP_DEL: entry_o = EMPTY_ENTRY;
      OP_INC: begin
        case (field_i)
          FLD_NOTE: if (seed.note < NMAX) entry_o.note = seed.note + 8'd1;
          FLD_OCT:  entry_o.note = (({1'b0, seed.note} + 9'd12) > {1'b0, NMAX}) ?
                                   NMAX : seed.note + 8'd12;
          FLD_VOL:  if (seed.vol < VOL_MAX) entry_o.vol = seed.vol + 6'd1;
          default:  if (seed.inst < INST_MAX) entry_o.inst = seed.inst + 2'd1;
        endcase
      end
      OP_DEC: begin
        case (field_i)
          FLD_NOTE: if (seed.note != 8'd0) entry_o.note = seed.note - 8'd1;
          FLD_OCT:  entry_o.note = (seed.note < 8'd12) ? 8'd0 : seed.note - 8'd12;
          FLD_VOL:  if (seed.vol != 6'd0) entry_o.vol = seed.vol - 6'd1;
          default:  if (seed.inst != 2'd0) entry_o.inst = seed.inst - 2'd1;
        endcase
      end
      default: entry_o = seed;
    endcase
  end

endmodule

// File: rtl/phrase_store.sv
// rtl/phrase_store.sv - multi-phrase tracker storage with command port and row sequencer
// Build option: PHRASE_STORE_CLEAR_EN enables op 00 as a whole-phrase clear sweep.
module phrase_store
  import phrase_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int NUM_ROWS    = 16,
  parameter int NUM_PHRASES = 4,
  parameter int NOTE_MAX    = 107,
  localparam int PW = (NUM_PHRASES > 1) ? $clog2(NUM_PHRASES) : 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RW = $clog2(NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_active_low,
  input  logic                 play,
  input  logic                 tick,
  input  logic [PW-1:0]        phrase_sel,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [1:0]           cmd_field,
  input  logic [PW-1:0]        cmd_phrase,
  input  logic [CW-1:0]        cmd_ch,
  input  logic [RW-1:0]        cmd_row,
  output logic                 cmd_done,
  output logic                 cmd_err,
  output logic [PW-1:0]        cur_phrase,
  output logic [RW-1:0]        cur_row,
  output logic                 wrap,
  output logic [NUM_CH*16-1:0] ch_data
);

  localparam int              DEPTH    = NUM_PHRASES * NUM_ROWS;
  localparam int              LW       = NUM_CH * 16;
  localparam logic [CW:0]     CH_LIMIT = NUM_CH[CW:0];
  localparam logic [RW-1:0]   LAST_ROW = RW'(NUM_ROWS - 1);

  // One word per (phrase, row) holding all channels side by side
  logic [LW-1:0] mem_q [DEPTH];

  state_e        state_q, state_d;
  cmd_op_e       op_q;
  cmd_field_e    field_q;
  logic [PW-1:0] ph_q;
  logic [CW-1:0] ch_q;
  logic [RW-1:0] row_q;
  entry_t        entry_q, alu_out;
  logic [PW-1:0] cur_phrase_q;
  logic [RW-1:0] cur_row_q;
  logic          wrap_q;
  logic [LW-1:0] ch_data_q;
  logic          accept, cmd_bad, step;

  assign accept = cmd_valid && (state_q == ST_IDLE);
  assign step   = tick && play;
`ifdef PHRASE_STORE_CLEAR_EN
  assign cmd_bad = play || ({1'b0, cmd_ch} >= CH_LIMIT);
`else
  assign cmd_bad = play || ({1'b0, cmd_ch} >= CH_LIMIT) || (cmd_op == OP_CLEAR);
`endif

  phrase_entry_alu #(.NOTE_MAX(NOTE_MAX)) u_alu (
    .op_i    (op_q),
    .field_i (field_q),
    .entry_i (entry_q),
    .entry_o (alu_out)
  );

`ifdef PHRASE_STORE_CLEAR_EN
  logic [RW-1:0] sweep_q;

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) sweep_q <= '0;
    else if (accept) sweep_q <= '0;
    else if (state_q == ST_SWEEP) sweep_q <= sweep_q + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    cmd_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_bad) state_d = ST_ERR;
`ifdef PHRASE_STORE_CLEAR_EN
          else if (cmd_op == OP_CLEAR) state_d = ST_SWEEP;
`endif
          else state_d = ST_READ;
        end
      end
      ST_READ:   state_d = ST_MODIFY;
      ST_MODIFY: state_d = ST_DONE;
      ST_DONE: begin
        cmd_done = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        cmd_err = 1'b1;
        state_d = ST_IDLE;
      end
`ifdef PHRASE_STORE_CLEAR_EN
      ST_SWEEP: if (sweep_q == LAST_ROW) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {NUM_CH{EMPTY_ENTRY}};
    end else if (state_q == ST_MODIFY) begin
      mem_q[{ph_q, row_q}][{ch_q, 4'b0000} +: 16] <= alu_out;
    end
`ifdef PHRASE_STORE_CLEAR_EN
    else if (state_q == ST_SWEEP) begin
      mem_q[{ph_q, sweep_q}] <= {NUM_CH{EMPTY_ENTRY}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_INC;
      field_q      <= FLD_NOTE;
      ph_q         <= '0;
      ch_q         <= '0;
      row_q        <= '0;
      entry_q      <= EMPTY_ENTRY;
      cur_phrase_q <= '0;
      cur_row_q    <= '0;
      wrap_q       <= 1'b0;
      ch_data_q    <= {NUM_CH{EMPTY_ENTRY}};
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= cmd_op_e'(cmd_op);
        field_q <= cmd_field_e'(cmd_field);
        ph_q    <= cmd_phrase;
        ch_q    <= cmd_ch;
        row_q   <= cmd_row;
      end
      if (state_q == ST_READ) entry_q <= mem_q[{ph_q, row_q}][{ch_q, 4'b0000} +: 16];
      // The new phrase is only picked up at the row wrap
      wrap_q <= step && (cur_row_q == LAST_ROW);
      if (step) begin
        if (cur_row_q == LAST_ROW) begin
          cur_row_q    <= '0;
          cur_phrase_q <= (NUM_PHRASES > 1) ? phrase_sel : '0;
        end else begin
          cur_row_q <= cur_row_q + 1'b1;
        end
      end
      ch_data_q <= mem_q[{cur_phrase_q, cur_row_q}];
    end
  end

  assign cur_phrase = cur_phrase_q;
  assign cur_row    = cur_row_q;
  assign wrap       = wrap_q;
  assign ch_data    = ch_data_q;

endmodule

// File: tb/tb_phrase_store.sv
// tb/tb_phrase_store.sv - directed vector bench for phrase_store (default parameters)
module tb_phrase_store;

  logic        clk = 1'b0;
  logic        rst_active_low;
  logic        play, tick;
  logic [1:0]  phrase_sel;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_field;
  logic [1:0]  cmd_phrase, cmd_ch;
  logic [3:0]  cmd_row;
  logic        cmd_done, cmd_err;
  logic [1:0]  cur_phrase;
  logic [3:0]  cur_row;
  logic        wrap;
  logic [63:0] ch_data;

  int n_checks = 0;
  int n_fail   = 0;

  phrase_store dut (
    .clk            (clk),
    .rst_active_low (rst_active_low),
    .play           (play),
    .tick           (tick),
    .phrase_sel     (phrase_sel),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_field      (cmd_field),
    .cmd_phrase     (cmd_phrase),
    .cmd_ch         (cmd_ch),
    .cmd_row        (cmd_row),
    .cmd_done       (cmd_done),
    .cmd_err        (cmd_err),
    .cur_phrase     (cur_phrase),
    .cur_row        (cur_row),
    .wrap           (wrap),
    .ch_data        (ch_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  fld;
    logic [1:0]  ch;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [1:0] fld, input logic [1:0] ph,
                        input logic [1:0] ch, input logic [3:0] row,
                        output int lat, output logic done, output logic err);
    int w;
    w = 0;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    cmd_op = op; cmd_field = fld; cmd_phrase = ph; cmd_ch = ch; cmd_row = row;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!cmd_done && !cmd_err && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    done = cmd_done;
    err  = cmd_err;
  endtask

  initial begin
    logic [63:0] model;
    logic [63:0] all_empty;
    logic [5:0]  expv;
    int          lat, k;
    logic        done, err, seen_done;

    all_empty = {4{16'hFFFF}};
    // op: 01 inc, 10 dec, 11 delete; field: 0 note, 1 octave, 2 vol, 3 inst
    vecs[0]  = '{2'b01, 2'd0, 2'd1, 16'h25C8};
    vecs[1]  = '{2'b01, 2'd1, 2'd1, 16'h31C8};
    vecs[2]  = '{2'b01, 2'd1, 2'd1, 16'h3DC8};
    vecs[3]  = '{2'b01, 2'd1, 2'd1, 16'h49C8};
    vecs[4]  = '{2'b01, 2'd1, 2'd1, 16'h55C8};
    vecs[5]  = '{2'b01, 2'd1, 2'd1, 16'h61C8};
    vecs[6]  = '{2'b01, 2'd1, 2'd1, 16'h6BC8};
    vecs[7]  = '{2'b01, 2'd1, 2'd1, 16'h6BC8};
    vecs[8]  = '{2'b01, 2'd0, 2'd1, 16'h6BC8};
    vecs[9]  = '{2'b10, 2'd0, 2'd1, 16'h6AC8};
    vecs[10] = '{2'b10, 2'd2, 2'd2, 16'h24C4};
    vecs[11] = '{2'b10, 2'd3, 2'd2, 16'h24C4};
    vecs[12] = '{2'b01, 2'd3, 2'd2, 16'h24C5};
    vecs[13] = '{2'b01, 2'd3, 2'd2, 16'h24C6};
    vecs[14] = '{2'b01, 2'd3, 2'd2, 16'h24C7};
    vecs[15] = '{2'b01, 2'd3, 2'd2, 16'h24C7};
    vecs[16] = '{2'b01, 2'd2, 2'd2, 16'h24CB};
    vecs[17] = '{2'b10, 2'd1, 2'd3, 16'h18C8};
    vecs[18] = '{2'b10, 2'd1, 2'd3, 16'h0CC8};
    vecs[19] = '{2'b10, 2'd1, 2'd3, 16'h00C8};
    vecs[20] = '{2'b10, 2'd1, 2'd3, 16'h00C8};
    vecs[21] = '{2'b10, 2'd0, 2'd3, 16'h00C8};
    vecs[22] = '{2'b11, 2'd0, 2'd1, 16'hFFFF};
    vecs[23] = '{2'b11, 2'd0, 2'd0, 16'hFFFF};

    rst_active_low = 1'b0;
    play = 1'b0; tick = 1'b0; phrase_sel = 2'd0;
    cmd_valid = 1'b0; cmd_op = 2'b01; cmd_field = 2'd0;
    cmd_phrase = 2'd0; cmd_ch = 2'd0; cmd_row = 4'd0;
    repeat (3) @(negedge clk);
    rst_active_low = 1'b1;
    @(negedge clk);
    chk("reset_ctl", 64'({cmd_ready, cmd_done, cmd_err, wrap}), 64'b1000);
    chk("reset_pos", 64'({cur_phrase, cur_row}), 64'd0);
    chk("reset_data", ch_data, all_empty);

    // step to row 2 of phrase 0 so edits there are displayed
    play = 1'b1; tick = 1'b1;
    repeat (2) @(negedge clk);
    play = 1'b0; tick = 1'b0;
    chk("seek_row2", 64'(cur_row), 64'd2);

    model = all_empty;
    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].fld, 2'd0, vecs[i].ch, 4'd2, lat, done, err);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_done", i), 64'({done, err}), 64'b10);
      @(negedge clk);
      model[vecs[i].ch*16 +: 16] = vecs[i].exp;
      chk($sformatf("vec%0d_data", i), ch_data, model);
    end

    for (int i = 1; i <= 14; i++) begin
      do_cmd(2'b01, 2'd2, 2'd0, 2'd0, 4'd2, lat, done, err);
      @(negedge clk);
      expv = (50 + i > 63) ? 6'd63 : 6'(50 + i);
      model[15:0] = {8'h24, expv, 2'b00};
      chk($sformatf("volsat%0d", i), ch_data, model);
    end

    // edit while playing is rejected and leaves storage alone
    play = 1'b1;
    do_cmd(2'b01, 2'd0, 2'd0, 2'd1, 4'd2, lat, done, err);
    chk("play_err", 64'({lat[7:0], done, err}), {54'd0, 8'd1, 2'b01});
    @(negedge clk);
    chk("play_err_ready", 64'(cmd_ready), 64'd1);
    chk("play_err_data", ch_data, model);
    play = 1'b0;

    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("paused_tick", 64'(cur_row), 64'd2);

    do_cmd(2'b01, 2'd3, 2'd2, 2'd0, 4'd0, lat, done, err);
    chk("ph2_wr_done", 64'({done, err}), 64'b10);
    @(negedge clk);
    chk("ph2_wr_hidden", ch_data, model);

    // play from row 2 to the wrap; phrase_sel changes mid-phrase
    phrase_sel = 2'd1; play = 1'b1; tick = 1'b1;
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (k == 5) phrase_sel = 2'd2;
      if (k == 10) chk("mid_pos", 64'({cur_phrase, cur_row}), 64'({2'd0, 4'd12}));
      if (wrap) break;
    end
    tick = 1'b0;
    chk("wrap_ticks", 64'(k), 64'd14);
    chk("wrap_pos", 64'({cur_phrase, cur_row}), 64'({2'd2, 4'd0}));
    chk("wrap_old_data", ch_data, all_empty);
    @(negedge clk);
    chk("wrap_pulse", 64'(wrap), 64'd0);
    chk("wrap_new_data", ch_data, {48'hFFFF_FFFF_FFFF, 16'h24C9});

    play = 1'b0; tick = 1'b1;
    @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("resume_row", 64'({cur_phrase, cur_row}), 64'({2'd2, 4'd1}));
    play = 1'b0;

    // reset lands while the command is in READ
    cmd_op = 2'b01; cmd_field = 2'd0; cmd_phrase = 2'd2; cmd_ch = 2'd0; cmd_row = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_active_low = 1'b0;
    #1;
    chk("rst_async", 64'({cmd_ready, cur_phrase, cur_row}), 64'({1'b1, 6'd0}));
    @(negedge clk);
    rst_active_low = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen_done = seen_done | cmd_done;
    end
    chk("rst_no_done", 64'({seen_done, cmd_ready}), 64'b01);
    chk("rst_data", ch_data, all_empty);

    phrase_sel = 2'd2; play = 1'b1; tick = 1'b1;
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (wrap) break;
    end
    tick = 1'b0; play = 1'b0;
    chk("wrap16_ticks", 64'(k), 64'd16);
    @(negedge clk);
    chk("rst_ph2_cleared", ch_data, all_empty);

`ifdef PHRASE_STORE_CLEAR_EN
    do_cmd(2'b01, 2'd0, 2'd2, 2'd3, 4'd0, lat, done, err);
    @(negedge clk);
    chk("pre_clear_data", ch_data, {16'h25C8, 48'hFFFF_FFFF_FFFF});
    do_cmd(2'b00, 2'd0, 2'd2, 2'd0, 4'd0, lat, done, err);
    chk("clear_lat", 64'(lat), 64'd17);
    chk("clear_done", 64'({done, err}), 64'b10);
    @(negedge clk);
    chk("clear_data", ch_data, all_empty);
`else
    do_cmd(2'b00, 2'd0, 2'd2, 2'd0, 4'd0, lat, done, err);
    chk("clear_off_err", 64'({lat[7:0], done, err}), {54'd0, 8'd1, 2'b01});
    @(negedge clk);
    chk("clear_off_ready", 64'(cmd_ready), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
